// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - register file with per-register busy scoreboard and optional write forwarding
module regfile_scoreboard #(
    parameter int DATA_WIDTH     = 32,
    parameter int REGISTERS      = 32,
    parameter int LOG2_REGISTERS = 5,
    parameter int READ_PORTS     = 2,
    parameter int BYPASS         = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [READ_PORTS*LOG2_REGISTERS-1:0] rd_addr,
    output logic [READ_PORTS*DATA_WIDTH-1:0]     rd_data,
    output logic [READ_PORTS-1:0]                rd_busy,
    input  logic                                wr_en,
    input  logic [LOG2_REGISTERS-1:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0]                wr_data,
    input  logic                                resv_en,
    input  logic [LOG2_REGISTERS-1:0]            resv_addr,
    output logic                                stall,
    output logic [LOG2_REGISTERS:0]              busy_count
);

    logic [DATA_WIDTH-1:0]   regs [REGISTERS];
    logic [REGISTERS-1:0]    busy;
    logic [REGISTERS-1:0]    busy_next;
    logic [LOG2_REGISTERS:0] count_next;

    // Next busy vector: a write retires its producer, a reservation applied
    // afterwards wins on the same register because it is the newer producer.
    always_comb begin
        busy_next = busy;
        if (wr_en) begin
            busy_next[wr_addr] = 1'b0;
        end
        if (resv_en && (resv_addr != '0)) begin
            busy_next[resv_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Popcount of the next busy vector so busy_count tracks the state after each edge.
    always_comb begin
        count_next = '0;
        for (int i = 0; i < REGISTERS; i++) begin
            count_next = count_next + {{LOG2_REGISTERS{1'b0}}, busy_next[i]};
        end
    end

    // State update: reset clears everything and overrides any write or reservation.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REGISTERS; i++) begin
                regs[i] <= '0;
            end
            busy       <= '0;
            busy_count <= '0;
        end else begin
            if (wr_en && (wr_addr != '0)) begin
                regs[wr_addr] <= wr_data;
            end
            busy       <= busy_next;
            busy_count <= count_next;
        end
    end

    genvar p;
    generate
        for (p = 0; p < READ_PORTS; p++) begin : g_read
            logic [LOG2_REGISTERS-1:0] addr;
            logic [DATA_WIDTH-1:0]     data;
            logic                      pend;

            assign addr = rd_addr[p*LOG2_REGISTERS +: LOG2_REGISTERS];

            // Combinational read: forward the in-flight write when enabled,
            // x0 is hard zero, and outputs are held quiet while in reset.
            always_comb begin
                data = regs[addr];
                pend = busy[addr];
                if ((BYPASS != 0) && wr_en && (addr == wr_addr)) begin
                    data = wr_data;
                    pend = 1'b0;
                end
                if (addr == '0) begin
                    data = '0;
                    pend = 1'b0;
                end
                if (rst) begin
                    data = '0;
                    pend = 1'b0;
                end
            end

            assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = data;
            assign rd_busy[p]                          = pend;
        end
    endgenerate

    assign stall = |rd_busy;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - scoreboard bench for regfile_scoreboard (forwarding and non-forwarding instances)
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst;

    logic [9:0]  rd_addr_a, rd_addr_b;
    logic [63:0] rd_data_a, rd_data_b;
    logic [1:0]  rd_busy_a, rd_busy_b;
    logic        wr_en_a, wr_en_b;
    logic [4:0]  wr_addr_a, wr_addr_b;
    logic [31:0] wr_data_a, wr_data_b;
    logic        resv_en_a, resv_en_b;
    logic [4:0]  resv_addr_a, resv_addr_b;
    logic        stall_a, stall_b;
    logic [5:0]  busy_count_a, busy_count_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        bit          dut;
        int          port;
        logic [31:0] data;
        bit          busy;
        bit          stall;
        logic [5:0]  count;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    logic [31:0] act_data;
    logic        act_busy;
    logic        act_stall;
    logic [5:0]  act_count;

    always #5 clk = ~clk;

    regfile_scoreboard #(.BYPASS(1)) dut_a (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr_a), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
        .resv_en(resv_en_a), .resv_addr(resv_addr_a),
        .stall(stall_a), .busy_count(busy_count_a)
    );

    regfile_scoreboard #(.BYPASS(0)) dut_b (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .resv_en(resv_en_b), .resv_addr(resv_addr_b),
        .stall(stall_b), .busy_count(busy_count_b)
    );

    // Monitor: mid-cycle, pop every pending expectation and compare with the DUT outputs.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            mon_e = q.pop_front();
            if (mon_e.dut == 1'b0) begin
                act_data  = rd_data_a[mon_e.port*32 +: 32];
                act_busy  = rd_busy_a[mon_e.port];
                act_stall = stall_a;
                act_count = busy_count_a;
            end else begin
                act_data  = rd_data_b[mon_e.port*32 +: 32];
                act_busy  = rd_busy_b[mon_e.port];
                act_stall = stall_b;
                act_count = busy_count_b;
            end
            checks++;
            if (act_data !== mon_e.data || act_busy !== mon_e.busy ||
                act_stall !== mon_e.stall || act_count !== mon_e.count) begin
                errors++;
                $display("FAIL %s: got data=%h busy=%b stall=%b count=%0d, want data=%h busy=%b stall=%b count=%0d",
                         mon_e.name, act_data, act_busy, act_stall, act_count,
                         mon_e.data, mon_e.busy, mon_e.stall, mon_e.count);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input bit d, input int p, input logic [31:0] data,
                       input bit b, input bit s, input logic [5:0] c);
        exp_t e;
        e.name = n; e.dut = d; e.port = p; e.data = data;
        e.busy = b; e.stall = s; e.count = c;
        q.push_back(e);
    endtask

    task automatic drive_a(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                           input bit re, input logic [4:0] ra,
                           input logic [4:0] r0, input logic [4:0] r1);
        wr_en_a = we; wr_addr_a = wa; wr_data_a = wd;
        resv_en_a = re; resv_addr_a = ra;
        rd_addr_a = {r1, r0};
    endtask

    task automatic drive_b(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                           input bit re, input logic [4:0] ra,
                           input logic [4:0] r0, input logic [4:0] r1);
        wr_en_b = we; wr_addr_b = wa; wr_data_b = wd;
        resv_en_b = re; resv_addr_b = ra;
        rd_addr_b = {r1, r0};
    endtask

    initial begin
        rst = 1'b1;
        drive_a(1, 5, 32'h1111_1111, 1, 6, 5, 6);
        drive_b(0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("reset_during", 0, 0, 32'h0, 0, 0, 6'd0);
        chk("reset_during_b", 1, 0, 32'h0, 0, 0, 6'd0);
        tick();
        rst = 1'b0;

        drive_a(1, 5, 32'hDEADBEEF, 0, 0, 1, 2);
        chk("x5_write_other", 0, 0, 32'h0, 0, 0, 6'd0);
        tick();
        drive_a(0, 0, 0, 0, 0, 5, 5);
        chk("x5_read_p0", 0, 0, 32'hDEADBEEF, 0, 0, 6'd0);
        chk("x5_read_p1", 0, 1, 32'hDEADBEEF, 0, 0, 6'd0);
        tick();

        drive_a(0, 0, 0, 1, 7, 7, 7);
        chk("x7_resv_same_cycle", 0, 0, 32'h0, 0, 0, 6'd0);
        tick();
        drive_a(0, 0, 0, 0, 0, 7, 7);
        chk("x7_busy_p0", 0, 0, 32'h0, 1, 1, 6'd1);
        chk("x7_busy_p1", 0, 1, 32'h0, 1, 1, 6'd1);
        tick();
        drive_a(1, 7, 32'h12, 0, 0, 7, 7);
        chk("x7_bypass_p0", 0, 0, 32'h12, 0, 0, 6'd1);
        chk("x7_bypass_p1", 0, 1, 32'h12, 0, 0, 6'd1);
        tick();
        drive_a(0, 0, 0, 0, 0, 7, 5);
        chk("x7_retired", 0, 0, 32'h12, 0, 0, 6'd0);
        tick();

        drive_a(1, 3, 32'h55, 1, 3, 3, 3);
        chk("x3_resv_wr_same", 0, 0, 32'h55, 0, 0, 6'd0);
        tick();
        drive_a(0, 0, 0, 0, 0, 3, 3);
        chk("x3_resv_wins_p0", 0, 0, 32'h55, 1, 1, 6'd1);
        chk("x3_resv_wins_p1", 0, 1, 32'h55, 1, 1, 6'd1);
        tick();
        drive_a(1, 3, 32'h66, 0, 0, 3, 3);
        chk("x3_rewrite_bypass", 0, 0, 32'h66, 0, 0, 6'd1);
        tick();
        drive_a(0, 0, 0, 0, 0, 3, 5);
        chk("x3_rewrite_done", 0, 0, 32'h66, 0, 0, 6'd0);
        tick();

        drive_a(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0);
        chk("x0_wr_resv_same", 0, 0, 32'h0, 0, 0, 6'd0);
        tick();
        drive_a(0, 0, 0, 0, 0, 0, 0);
        chk("x0_after_p0", 0, 0, 32'h0, 0, 0, 6'd0);
        chk("x0_after_p1", 0, 1, 32'h0, 0, 0, 6'd0);
        tick();

        drive_a(1, 11, 32'h77, 1, 10, 10, 11);
        chk("split_same_p0", 0, 0, 32'h0, 0, 0, 6'd0);
        chk("split_same_p1", 0, 1, 32'h77, 0, 0, 6'd0);
        tick();
        drive_a(0, 0, 0, 0, 0, 10, 11);
        chk("split_after_p0", 0, 0, 32'h0, 1, 1, 6'd1);
        chk("split_after_p1", 0, 1, 32'h77, 0, 1, 6'd1);
        tick();
        drive_a(0, 0, 0, 1, 10, 10, 10);
        chk("resv_busy_again", 0, 0, 32'h0, 1, 1, 6'd1);
        tick();
        drive_a(0, 0, 0, 0, 0, 10, 10);
        chk("resv_busy_held", 0, 0, 32'h0, 1, 1, 6'd1);
        tick();

        for (int i = 1; i < 32; i++) begin
            drive_a(0, 0, 0, 1, i[4:0], 0, 0);
            tick();
        end
        rst = 1'b1;
        drive_a(1, 4, 32'h99, 0, 0, 4, 5);
        chk("full_count_in_reset", 0, 0, 32'h0, 0, 0, 6'd31);
        chk("full_in_reset_p1", 0, 1, 32'h0, 0, 0, 6'd31);
        tick();
        rst = 1'b0;
        drive_a(0, 0, 0, 0, 0, 4, 5);
        chk("post_reset_p0", 0, 0, 32'h0, 0, 0, 6'd0);
        chk("post_reset_p1", 0, 1, 32'h0, 0, 0, 6'd0);
        tick();
        drive_a(1, 4, 32'h44, 0, 0, 4, 4);
        chk("post_reset_write", 0, 0, 32'h44, 0, 0, 6'd0);
        tick();
        drive_a(0, 0, 0, 0, 0, 4, 4);
        chk("post_reset_read", 0, 1, 32'h44, 0, 0, 6'd0);
        tick();

        drive_b(1, 9, 32'hA5, 0, 0, 9, 9);
        chk("nobyp_same_cycle", 1, 0, 32'h0, 0, 0, 6'd0);
        tick();
        drive_b(0, 0, 0, 0, 0, 9, 9);
        chk("nobyp_next_cycle", 1, 1, 32'hA5, 0, 0, 6'd0);
        tick();
        drive_b(0, 0, 0, 1, 9, 9, 9);
        chk("nobyp_resv_same", 1, 0, 32'hA5, 0, 0, 6'd0);
        tick();
        drive_b(1, 9, 32'hB6, 0, 0, 9, 9);
        chk("nobyp_busy_on_write", 1, 0, 32'hA5, 1, 1, 6'd1);
        tick();
        drive_b(0, 0, 0, 0, 0, 9, 9);
        chk("nobyp_retired", 1, 0, 32'hB6, 0, 0, 6'd0);
        tick();

        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            tick();
        end
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
